jtkcpu_busresp: RTL and testbench

Memory-side responder for the KCPU memory controller. It generates the cen2/cen clock enables that pace the CPU and decodes every CPU address. Low addresses are served from internal RAM with zero wait states. All other addresses are forwarded to an external req/ack port, and the CPU is stretched (cen2/cen withheld) until the external side acknowledges. It sits between the CPU core and the game's ROM/IO bus.

---
 rtl/jtkcpu_busresp_pkg.sv | 22 ++
 rtl/jtkcpu_busresp_if.sv | 21 ++
 rtl/jtkcpu_busresp_ram.sv | 31 +++
 rtl/jtkcpu_busresp.sv | 156 +++++++++++++++
 tb/tb_jtkcpu_busresp.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtkcpu_busresp_pkg.sv
// jtkcpu_busresp_pkg
// Shared constants for the KCPU bus responder: FSM state encodings, the
// external-access timeout limit and the internal-RAM address decode helper.
// No ports.
package jtkcpu_busresp_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXT  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Number of clk cycles an external access may wait before being aborted.
   localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

   // True when addr falls inside the internal RAM window 0 .. 2**aw-1.
   // Written as a shift so that aw=16 (whole map internal) still works.
   function automatic logic is_ram_addr(input logic [15:0] addr, input int aw);
      logic [15:0] hi;
      hi = addr >> aw;
      return hi == 16'd0;
   endfunction

endpackage

// File: rtl/jtkcpu_busresp_if.sv
// jtkcpu_busresp_if
// External ROM/IO request port of the KCPU bus responder.
//   addr  16  external address, latched at request
//   dout   8  external write data, latched at request
//   we     1  write qualifier, valid while req=1
//   req    1  access request, level
//   ack    1  completion, one clk pulse; din valid with it
//   din    8  external read data
// master: the responder (drives addr/dout/we/req)
// slave : the ROM/IO side (drives ack/din)
interface jtkcpu_busresp_if;
   logic [15:0] addr;
   logic [7:0]  dout;
   logic        we;
   logic        req;
   logic        ack;
   logic [7:0]  din;

   modport master (output addr, dout, we, req, input ack, din);
   modport slave  (input addr, dout, we, req, output ack, din);
endinterface

// File: rtl/jtkcpu_busresp_ram.sv
// jtkcpu_busresp_ram
// Single-port synchronous RAM, 2**AW x 8, kept on its own so that FPGA
// block RAM inference is not disturbed by the surrounding control logic.
//   clk   clock
//   addr  AW-bit address
//   din   write data
//   we    write enable
//   re    read enable; q only changes on a read so it holds the last read
//   q     registered read data
module jtkcpu_busresp_ram #(
   parameter int AW = 11
)(
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    din,
   input  logic          we,
   input  logic          re,
   output logic [7:0]    q
);

   logic [7:0] mem [0:(1<<AW)-1];

   // Contents are deliberately not reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= din;
      else if (re)
         q <= mem[addr];
   end

endmodule

// File: rtl/jtkcpu_busresp.sv
// jtkcpu_busresp
// Memory-side responder for the KCPU memory controller. Paces the CPU with
// cen2/cen, serves low addresses from internal RAM with no wait states and
// forwards every other address to the external req/ack port, withholding
// cen2/cen until the external side acknowledges.
// Optional feature: define JTKCPU_BUSRESP_TIMEOUT_EN to abort external
// accesses that see no ack within 255 clk (cpu_din forced to 8'hFF and a
// one-clk timeout pulse). Without it EXT waits forever and timeout is 0.
// Ports:
//   rst       asynchronous reset, active-high
//   clk       clock
//   cen2      CPU fast enable, one clk wide
//   cen       CPU slow enable, every second cen2
//   cpu_addr  CPU address
//   cpu_dout  CPU write data
//   cpu_we    CPU write strobe
//   cpu_din   read data returned to the CPU
//   ext       external request port (master side)
//   timeout   one-clk pulse on an aborted access
module jtkcpu_busresp
   import jtkcpu_busresp_pkg::*;
#(
   parameter int RAM_AW = 11,
   parameter int DIV    = 2
)(
   input  logic                   rst,
   input  logic                   clk,
   output logic                   cen2,
   output logic                   cen,
   input  logic [15:0]            cpu_addr,
   input  logic [7:0]             cpu_dout,
   input  logic                   cpu_we,
   output logic [7:0]             cpu_din,
   jtkcpu_busresp_if.master       ext,
   output logic                   timeout
);

   localparam logic [3:0] CNT_LAST = 4'(DIV - 1);

   logic [1:0] state;
   logic [3:0] cnt;
   logic       phase;
   logic       fresh;
   logic       src_ram;
   logic [7:0] din_r;
   logic [7:0] ram_q;
   logic       ram_hit;
   logic       decode;
   logic       ram_we;
   logic       ram_re;

`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
   logic [7:0] tcnt;
`else
   assign timeout = 1'b0;
`endif

   // cen2 is decoded from registered state, so it is glitch-free and
   // naturally low in reset (cnt=0 and DIV>=2). The slot after it can never
   // have cnt==DIV-1, so decode and cen2 never coincide.
   assign cen2    = (state == ST_IDLE) && (cnt == CNT_LAST);
   assign cen     = cen2 && phase;
   assign ram_hit = is_ram_addr(cpu_addr, RAM_AW);
   assign decode  = (state == ST_IDLE) && fresh;
   assign ram_we  = decode && ram_hit && cpu_we;
   assign ram_re  = decode && ram_hit && !cpu_we;

   // RAM reads are returned straight from the RAM output register, so the
   // data appears one clk after the decode slot; din_r holds external data.
   assign cpu_din = src_ram ? ram_q : din_r;

   jtkcpu_busresp_ram #(.AW(RAM_AW)) u_ram (
      .clk  (clk),
      .addr (cpu_addr[RAM_AW-1:0]),
      .din  (cpu_dout),
      .we   (ram_we),
      .re   (ram_re),
      .q    (ram_q)
   );

   // Divider, cen phase and access FSM. The divider only advances in IDLE
   // and is frozen while an external access is outstanding; leaving DONE
   // preloads it so cen2 fires on the very next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= 4'd0;
         phase    <= 1'b0;
         fresh    <= 1'b0;
         src_ram  <= 1'b0;
         din_r    <= 8'h00;
         ext.addr <= 16'h0000;
         ext.dout <= 8'h00;
         ext.we   <= 1'b0;
         ext.req  <= 1'b0;
`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
         tcnt     <= 8'd0;
         timeout  <= 1'b0;
`endif
      end else begin
         fresh <= cen2;
         if (cen2)
            phase <= ~phase;
         if (ram_re)
            src_ram <= 1'b1;
`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
         timeout <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (decode && !ram_hit) begin
                  ext.addr <= cpu_addr;
                  ext.dout <= cpu_dout;
                  ext.we   <= cpu_we;
                  ext.req  <= 1'b1;
                  state    <= ST_EXT;
`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
                  tcnt     <= 8'd0;
`endif
               end else begin
                  cnt <= cen2 ? 4'd0 : cnt + 4'd1;
               end
            end
            ST_EXT: begin
               if (ext.ack) begin
                  if (!ext.we) begin
                     din_r   <= ext.din;
                     src_ram <= 1'b0;
                  end
                  ext.req <= 1'b0;
                  ext.we  <= 1'b0;
                  state   <= ST_DONE;
               end
`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
               else if (tcnt == TIMEOUT_LIMIT - 8'd1) begin
                  ext.req <= 1'b0;
                  ext.we  <= 1'b0;
                  din_r   <= 8'hFF;
                  src_ram <= 1'b0;
                  timeout <= 1'b1;
                  state   <= ST_DONE;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
`endif
            end
            ST_DONE: begin
               cnt   <= CNT_LAST;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtkcpu_busresp.sv
// tb_jtkcpu_busresp
// Self-checking bench for jtkcpu_busresp. The bench plays the CPU (changes
// the address on the clk after each cen2) and the external ROM/IO side.
// Expected values come from a behavioural model: a RAM array, the last value
// the CPU should read, and the cycle rules of the divider/ext handshake.
// With JTKCPU_BUSRESP_TIMEOUT_EN defined the timeout scenario is also run.
module tb_jtkcpu_busresp;

   localparam int DIV    = 2;
   localparam int RAM_AW = 11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cen2, cen, timeout;
   logic [15:0] cpu_addr = 16'h0100;
   logic [7:0]  cpu_dout = 8'h00;
   logic        cpu_we   = 1'b0;
   logic [7:0]  cpu_din;
   logic [7:0]  exp_din;
   int          total = 0;
   int          bad   = 0;
   int          req_cycles = 0;

   jtkcpu_busresp_if bus ();

   jtkcpu_busresp #(.RAM_AW(RAM_AW), .DIV(DIV)) dut (
      .rst      (rst),
      .clk      (clk),
      .cen2     (cen2),
      .cen      (cen),
      .cpu_addr (cpu_addr),
      .cpu_dout (cpu_dout),
      .cpu_we   (cpu_we),
      .cpu_din  (cpu_din),
      .ext      (bus),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   // Number of clk cycles in which a request was outstanding.
   always @(posedge clk) if (bus.req === 1'b1) req_cycles++;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Waits (bounded) for the next cycle with cen2 high, sampled on negedge.
   task automatic wait_cen2(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = cen2;
      end
   endtask

   // Drives one CPU access in the slot after the current cen2, then waits
   // for the following cen2.
   task automatic issue(input logic [15:0] a, input logic w, input logic [7:0] d, output bit ok);
      @(posedge clk); #1;
      cpu_addr = a; cpu_we = w; cpu_dout = d;
      wait_cen2(ok);
   endtask

   task automatic test_reset();
      bus.ack = 1'b0; bus.din = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (cen2 !== 1'b0)        begin bad++; $display("[TB] FAIL reset_cen2: got %b want 0", cen2); end
      total++; if (cen !== 1'b0)         begin bad++; $display("[TB] FAIL reset_cen: got %b want 0", cen); end
      total++; if (cpu_din !== 8'h00)    begin bad++; $display("[TB] FAIL reset_cpu_din: got %h want 00", cpu_din); end
      total++; if (bus.req !== 1'b0)     begin bad++; $display("[TB] FAIL reset_req: got %b want 0", bus.req); end
      total++; if (bus.we !== 1'b0)      begin bad++; $display("[TB] FAIL reset_we: got %b want 0", bus.we); end
      total++; if (bus.addr !== 16'h0)   begin bad++; $display("[TB] FAIL reset_addr: got %h want 0000", bus.addr); end
      total++; if (bus.dout !== 8'h0)    begin bad++; $display("[TB] FAIL reset_dout: got %h want 00", bus.dout); end
      total++; if (timeout !== 1'b0)     begin bad++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout); end
      rst = 1'b0;
   endtask

   // The divider starts at 0, so the first cen2 comes DIV-1 clk after
   // release; afterwards one every DIV clk, with cen on every second one.
   task automatic test_divider();
      int  last = 0;
      int  pulses = 0;
      int  stray = 0;
      logic exp_cen = 1'b0;
      for (int t = 1; t <= 10 * DIV && pulses < 8; t++) begin
         @(negedge clk);
         if (!cen2 && cen) stray++;
         if (cen2) begin
            if (pulses == 0) begin
               total++; if (t != DIV - 1) begin bad++; $display("[TB] FAIL div_first: got %0d want %0d", t, DIV - 1); end
            end else begin
               total++; if (t - last != DIV) begin bad++; $display("[TB] FAIL div_period: got %0d want %0d", t - last, DIV); end
            end
            total++; if (cen !== exp_cen) begin bad++; $display("[TB] FAIL div_cen%0d: got %b want %b", pulses, cen, exp_cen); end
            exp_cen = ~exp_cen;
            last = t;
            pulses++;
         end
      end
      total++; if (pulses != 8) begin bad++; $display("[TB] FAIL div_count: got %0d want 8", pulses); end
      total++; if (stray != 0)  begin bad++; $display("[TB] FAIL div_cen_alone: got %0d want 0", stray); end
   endtask

   task automatic test_ram();
      logic [7:0]  model [logic [15:0]];
      logic [15:0] a [8];
      logic [7:0]  d [8];
      bit ok;
      int req0;
      req0 = req_cycles;
      a[0] = 16'h0010; d[0] = 8'h5A;
      for (int i = 1; i < 8; i++) begin
         a[i] = 16'($urandom_range(0, (1 << RAM_AW) - 1));
         d[i] = 8'($urandom);
      end
      for (int i = 0; i < 8; i++) begin
         issue(a[i], 1'b1, d[i], ok);
         model[a[i]] = d[i];
         total++; if (!ok) begin bad++; $display("[TB] FAIL ram_wr_cen2: got none want cen2"); end
      end
      for (int i = 7; i >= 0; i--) begin
         issue(a[i], 1'b0, 8'h00, ok);
         total++; if (!ok) begin bad++; $display("[TB] FAIL ram_rd_cen2: got none want cen2"); end
         total++;
         if (cpu_din !== model[a[i]]) begin
            bad++; $display("[TB] FAIL ram_rd %h: got %h want %h", a[i], cpu_din, model[a[i]]);
         end
         exp_din = model[a[i]];
      end
      total++; if (req_cycles != req0) begin bad++; $display("[TB] FAIL ram_no_req: got %0d want 0", req_cycles - req0); end
   endtask

   task automatic test_ext_read();
      bit seen = 1'b0;
      int req0, c2 = 0;
      req0 = req_cycles;
      @(posedge clk); #1;
      cpu_addr = 16'h8000; cpu_we = 1'b0; cpu_dout = 8'h00;
      for (int i = 0; i < 8 && !seen; i++) begin @(negedge clk); seen = bus.req; end
      total++; if (!seen) begin bad++; $display("[TB] FAIL extrd_req: got 0 want 1"); end
      total++; if (bus.addr !== 16'h8000) begin bad++; $display("[TB] FAIL extrd_addr: got %h want 8000", bus.addr); end
      total++; if (bus.we !== 1'b0) begin bad++; $display("[TB] FAIL extrd_we: got %b want 0", bus.we); end
      for (int i = 0; i < 4; i++) begin @(negedge clk); if (cen2) c2++; end
      bus.din = 8'hC3; bus.ack = 1'b1;
      @(posedge clk); #1;
      bus.ack = 1'b0; bus.din = 8'($urandom);
      total++; if (req_cycles - req0 != 5) begin bad++; $display("[TB] FAIL extrd_req_len: got %0d want 5", req_cycles - req0); end
      @(negedge clk);
      if (cen2) c2++;
      total++; if (c2 != 0) begin bad++; $display("[TB] FAIL extrd_stall: got %0d cen2 want 0", c2); end
      total++; if (bus.req !== 1'b0) begin bad++; $display("[TB] FAIL extrd_req_drop: got %b want 0", bus.req); end
      @(negedge clk);
      total++; if (cen2 !== 1'b1) begin bad++; $display("[TB] FAIL extrd_resume: got %b want 1", cen2); end
      total++; if (cpu_din !== 8'hC3) begin bad++; $display("[TB] FAIL extrd_data: got %h want c3", cpu_din); end
      exp_din = 8'hC3;
   endtask

   task automatic test_ext_write();
      bit seen = 1'b0;
      int hi = 0;
      @(posedge clk); #1;
      cpu_addr = 16'h4000; cpu_we = 1'b1; cpu_dout = 8'h77;
      for (int i = 0; i < 8 && !seen; i++) begin @(negedge clk); seen = bus.req; end
      total++; if (!seen) begin bad++; $display("[TB] FAIL extwr_req: got 0 want 1"); end
      for (int i = 0; i < 3; i++) begin
         if (bus.req && bus.we === 1'b1 && bus.dout === 8'h77 && bus.addr === 16'h4000) hi++;
         @(negedge clk);
      end
      total++; if (hi != 3) begin bad++; $display("[TB] FAIL extwr_fields: got %0d good cycles want 3", hi); end
      bus.din = 8'($urandom); bus.ack = 1'b1;
      @(posedge clk); #1;
      bus.ack = 1'b0;
      @(negedge clk);
      total++; if (bus.we !== 1'b0) begin bad++; $display("[TB] FAIL extwr_we_drop: got %b want 0", bus.we); end
      @(negedge clk);
      total++; if (cen2 !== 1'b1) begin bad++; $display("[TB] FAIL extwr_resume: got %b want 1", cen2); end
      total++; if (cpu_din !== exp_din) begin bad++; $display("[TB] FAIL extwr_din_kept: got %h want %h", cpu_din, exp_din); end
   endtask

   // Random external reads/writes, each started in the slot right after the
   // previous access completed, with random ack latency.
   task automatic test_back_to_back();
      for (int k = 0; k < 8; k++) begin
         logic [15:0] a;
         logic        w;
         logic [7:0]  d, rd;
         int          dly, req0, c2;
         bit          seen;
         a = 16'($urandom_range(32'h0800, 32'hFFFF));
         w = 1'($urandom_range(0, 1));
         d = 8'($urandom); rd = 8'($urandom);
         dly = $urandom_range(0, 5);
         req0 = req_cycles; c2 = 0; seen = 1'b0;
         @(posedge clk); #1;
         cpu_addr = a; cpu_we = w; cpu_dout = d;
         for (int i = 0; i < 8 && !seen; i++) begin @(negedge clk); seen = bus.req; end
         total++; if (!seen) begin bad++; $display("[TB] FAIL b2b%0d_req: got 0 want 1", k); end
         total++;
         if ({bus.addr, bus.we, bus.dout} !== {a, w, d}) begin
            bad++; $display("[TB] FAIL b2b%0d_fields: got %h/%b/%h want %h/%b/%h", k, bus.addr, bus.we, bus.dout, a, w, d);
         end
         for (int i = 0; i < dly; i++) begin @(negedge clk); if (cen2) c2++; end
         bus.din = rd; bus.ack = 1'b1;
         @(posedge clk); #1;
         bus.ack = 1'b0;
         if (!w) exp_din = rd;
         total++; if (req_cycles - req0 != dly + 1) begin bad++; $display("[TB] FAIL b2b%0d_req_len: got %0d want %0d", k, req_cycles - req0, dly + 1); end
         @(negedge clk);
         if (cen2) c2++;
         total++; if (c2 != 0) begin bad++; $display("[TB] FAIL b2b%0d_stall: got %0d cen2 want 0", k, c2); end
         @(negedge clk);
         total++; if (cen2 !== 1'b1) begin bad++; $display("[TB] FAIL b2b%0d_resume: got %b want 1", k, cen2); end
         total++; if (cpu_din !== exp_din) begin bad++; $display("[TB] FAIL b2b%0d_din: got %h want %h", k, cpu_din, exp_din); end
      end
   endtask

   task automatic test_reset_mid_access();
      bit seen = 1'b0;
      int n = 0;
      @(posedge clk); #1;
      cpu_addr = 16'h9000; cpu_we = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin @(negedge clk); seen = bus.req; end
      total++; if (!seen) begin bad++; $display("[TB] FAIL rstmid_req: got 0 want 1"); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (bus.req !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_req_drop: got %b want 0", bus.req); end
      total++; if (cen2 !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_cen2: got %b want 0", cen2); end
      total++; if (cpu_din !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_din: got %h want 00", cpu_din); end
      cpu_addr = 16'h0100;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 20 && n == 0; i++) begin @(negedge clk); if (cen2) n = i; end
      total++; if (n != DIV - 1) begin bad++; $display("[TB] FAIL rstmid_first_cen2: got %0d want %0d", n, DIV - 1); end
      total++; if (cen !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_first_cen: got %b want 0", cen); end
      exp_din = 8'h00;
   endtask

`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
   task automatic test_timeout();
      bit seen = 1'b0;
      int n = 0;
      @(posedge clk); #1;
      cpu_addr = 16'hA000; cpu_we = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin @(negedge clk); seen = bus.req; end
      total++; if (!seen) begin bad++; $display("[TB] FAIL tmo_req: got 0 want 1"); end
      for (int i = 1; i <= 400 && n == 0; i++) begin @(negedge clk); if (timeout) n = i; end
      total++; if (n != 255) begin bad++; $display("[TB] FAIL tmo_delay: got %0d want 255", n); end
      total++; if (bus.req !== 1'b0) begin bad++; $display("[TB] FAIL tmo_req_drop: got %b want 0", bus.req); end
      total++; if (cpu_din !== 8'hFF) begin bad++; $display("[TB] FAIL tmo_din: got %h want ff", cpu_din); end
      @(negedge clk);
      total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL tmo_pulse: got %b want 0", timeout); end
      total++; if (cen2 !== 1'b1) begin bad++; $display("[TB] FAIL tmo_resume: got %b want 1", cen2); end
      exp_din = 8'hFF;
   endtask
`endif

   initial begin
      exp_din = 8'h00;
      test_reset();
      test_divider();
      test_ram();
      test_ext_read();
      test_ext_write();
      test_back_to_back();
      test_reset_mid_access();
`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
